// File: rtl/ram_march_tester.sv
// RAM march tester: write pass then read/verify pass over an owned RAM, four selectable patterns.
// Latency: start sampled in cycle T -> done_o first high in T+2*DEPTH+2.
// Backpressure: none; start_i is ignored while busy, mode_i is latched on accept.
// Optional: define RAM_MARCH_ERR_INJ_EN to corrupt bit 0 of chunk 0 at INJ_ADDR during the write pass.
module ram_march_tester #(
    parameter int RAM_ADDR_W = 8,
    parameter int CHUNK_W    = 32,
    parameter int CHUNK_CNT  = 1,
    parameter int MAGIC      = 0,
    parameter int ERR_CNT_W  = 16,
    parameter int INJ_ADDR   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ERR_CNT_W-1:0]  err_cnt_o,
    output logic                  first_err_valid_o,
    output logic [RAM_ADDR_W-1:0] first_err_addr_o
);

    localparam int DEPTH = 1 << RAM_ADDR_W;
    localparam int DW    = CHUNK_W * CHUNK_CNT;
    localparam logic [RAM_ADDR_W-1:0] LAST_ADDR = {RAM_ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [RAM_ADDR_W-1:0]   r_addr;
    logic [1:0]              r_mode;
    logic [ERR_CNT_W-1:0]    r_err_cnt;
    logic                    r_first_vld;
    logic [RAM_ADDR_W-1:0]   r_first_addr;
    logic                    r_pass;

    // Read pipeline: data comes back one cycle after the address, so the address rides along
    logic                    r_cmp_vld;
    logic [RAM_ADDR_W-1:0]   r_cmp_addr;
    logic [DW-1:0]           r_rd_dat;

    logic [DW-1:0]           r_mem [DEPTH];

    logic                    w_busy;
    logic                    w_done;
    logic                    w_we;
    logic                    w_rd_issue;
    logic                    w_start_ok;
    logic [DW-1:0]           w_wdat;
    logic [DW-1:0]           w_exp_dat;
    logic                    w_mismatch;

    // Pattern generator: one CHUNK_W slice per chunk, all arithmetic truncated to CHUNK_W
    function automatic logic [DW-1:0] f_pat(input logic [RAM_ADDR_W-1:0] a, input logic [1:0] m);
        logic [DW-1:0]      w;
        logic [CHUNK_W-1:0] s;
        logic [CHUNK_W-1:0] ch;
        int                 idx;
        w = '0;
        for (int c = 0; c < CHUNK_CNT; c++) begin
            s   = CHUNK_W'(a) + CHUNK_W'(c) + CHUNK_W'(MAGIC);
            idx = (int'(a) + c) % CHUNK_W;
            case (m)
                2'd0:    ch = s;
                2'd1:    ch = {{(CHUNK_W-1){1'b0}}, 1'b1} << idx;
                2'd2:    ch = {CHUNK_W{a[0]}};
                default: ch = ~s;
            endcase
            w[c*CHUNK_W +: CHUNK_W] = ch;
        end
        return w;
    endfunction

    assign w_start_ok = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; end of each pass is detected by comparing against the last address
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = S_WRITE;
            S_WRITE: if (r_addr == LAST_ADDR) w_state_nxt = S_READ;
            S_READ:  if (r_addr == LAST_ADDR) w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = S_DONE;
            S_DONE:  if (start_i) w_state_nxt = S_WRITE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded controls
    always_comb begin
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_we       = 1'b0;
        w_rd_issue = 1'b0;
        case (r_state)
            S_WRITE: begin w_busy = 1'b1; w_we = 1'b1; end
            S_READ:  begin w_busy = 1'b1; w_rd_issue = 1'b1; end
            S_FLUSH: w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Write data, with the optional single-bit corruption used to prove the comparator works
    always_comb begin
        w_wdat = f_pat(r_addr, r_mode);
`ifdef RAM_MARCH_ERR_INJ_EN
        if (r_addr == RAM_ADDR_W'(INJ_ADDR)) begin
            w_wdat[0] = ~w_wdat[0];
        end
`endif
    end

    assign w_exp_dat  = f_pat(r_cmp_addr, r_mode);
    assign w_mismatch = r_cmp_vld && (r_rd_dat != w_exp_dat);

    // RAM with registered read port; contents deliberately survive reset
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            r_mem[r_addr] <= w_wdat;
        end
        r_rd_dat   <= r_mem[r_addr];
        r_cmp_addr <= r_addr;
    end

    // Address, mode, error bookkeeping and verdict
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr       <= '0;
            r_mode       <= 2'd0;
            r_err_cnt    <= '0;
            r_first_vld  <= 1'b0;
            r_first_addr <= '0;
            r_pass       <= 1'b0;
            r_cmp_vld    <= 1'b0;
        end else begin
            r_cmp_vld <= w_rd_issue;
            if (w_mismatch) begin
                if (r_err_cnt != {ERR_CNT_W{1'b1}}) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                if (!r_first_vld) begin
                    r_first_vld  <= 1'b1;
                    r_first_addr <= r_cmp_addr;
                end
            end
            if (w_start_ok) begin
                r_addr       <= '0;
                r_mode       <= mode_i;
                r_err_cnt    <= '0;
                r_first_vld  <= 1'b0;
                r_first_addr <= '0;
                r_pass       <= 1'b0;
            end else if (w_we || w_rd_issue) begin
                r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
            end
            // Final compare happens in FLUSH, so fold it into the verdict taken on entry to DONE
            if (r_state == S_FLUSH) begin
                r_pass <= (r_err_cnt == '0) && !w_mismatch;
            end
        end
    end

    assign busy_o            = w_busy;
    assign done_o            = w_done;
    assign pass_o            = r_pass;
    assign err_cnt_o         = r_err_cnt;
    assign first_err_valid_o = r_first_vld;
    assign first_err_addr_o  = r_first_addr;

endmodule

// File: doc/ram_march_tester.md
Name: ram_march_tester

Overview:
- Self-contained, parametrised RAM test engine; successor to the fixed single-pattern ram_test engine.
- Owns an inferred single-port RAM of 2^RAM_ADDR_W words, each CHUNK_CNT*CHUNK_W bits wide.
- On request it runs a full write pass, then a read/verify pass, using one of four selectable patterns. Reports pass/fail, a saturating error count and the first failing address.
- Instantiated N times from the top-level generate loop; MAGIC differentiates instances.

Parameters:
- RAM_ADDR_W, 8, address width; DEPTH = 2^RAM_ADDR_W.
- CHUNK_W, 32, bits per chunk.
- CHUNK_CNT, 1, chunks per RAM word; word width DW = CHUNK_W*CHUNK_CNT.
- MAGIC, 0, per-instance seed mixed into patterns.
- ERR_CNT_W, 16, width of error counter.
- INJ_ADDR, 0, address corrupted when error injection is compiled in.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  run request; sampled only in IDLE or DONE.
- mode_i  input  2  pattern select; latched when start is accepted.
- busy_o  output  1  high from the cycle after start is accepted until done_o.
- done_o  output  1  high in DONE state; held until the next start or reset.
- pass_o  output  1  valid when done_o is high; 1 = zero errors.
- err_cnt_o  output  ERR_CNT_W  mismatching words in the current/last run; saturates at all-ones.
- first_err_valid_o  output  1  at least one mismatch seen this run.
- first_err_addr_o  output  RAM_ADDR_W  address of the first mismatch.

Behaviour:
- Reset values: state IDLE; busy_o=0, done_o=0, pass_o=0, err_cnt_o=0, first_err_valid_o=0, first_err_addr_o=0. RAM contents are not cleared.
- Pattern pat(a,c) for chunk c of address a, with every term truncated to CHUNK_W bits:
  - mode 0: a + c + MAGIC.
  - mode 1: walking one; only bit ((a + c) mod CHUNK_W) set.
  - mode 2: all-ones if a[0]=1, else all-zeros.
  - mode 3: bitwise NOT of mode 0.
- FSM states: IDLE, WRITE, READ, FLUSH, DONE.
  - IDLE/DONE + start_i=1 -> WRITE. Clear err_cnt, first_err_*, done_o, pass_o; latch mode; addr=0.
  - WRITE: write pat(addr,*) to addr, one word per cycle. At addr=DEPTH-1 go to READ with addr=0.
  - READ: issue a read of addr each cycle. RAM read data is registered, one cycle latency. Compare data against pat of the previous address (pipelined address/valid register). At addr=DEPTH-1 go to FLUSH.
  - FLUSH: perform the final compare -> DONE.
  - DONE: done_o=1. pass_o = (err_cnt==0), registered on entry to DONE.
- Latency: start_i sampled high in cycle T -> done_o first high in cycle T+2*DEPTH+2. busy_o is high in cycles T+1 .. T+2*DEPTH+1.
- Any mismatch in any chunk counts as one error for that word.
  - err_cnt increments by 1 and saturates at 2^ERR_CNT_W-1.
  - The first mismatch sets first_err_valid_o=1 and captures first_err_addr_o; later mismatches do not update it.
- start_i while busy is ignored. mode_i changes while busy have no effect.
- Start in the same cycle as DONE -> new run begins and done_o drops the next cycle.
- rst_i mid-run: next cycle is IDLE with all outputs at reset values. Rerunning after reset must give a correct result regardless of stale RAM contents.
- Address counter is RAM_ADDR_W bits; wrap is detected by compare with DEPTH-1, not by overflow.

Optional Feature:
- Macro RAM_MARCH_ERR_INJ_EN.
- Defined: during WRITE, the word written at INJ_ADDR has bit 0 of chunk 0 inverted. The read pass must therefore report exactly one error at INJ_ADDR (self-check of the comparator).
- Undefined: no corruption logic is generated, and INJ_ADDR is unused.

Test Plan:
- RAM_ADDR_W=4, CHUNK_W=8, CHUNK_CNT=2, MAGIC=3, mode 0, start pulse at cycle T -> done_o rises at T+34, pass_o=1, err_cnt_o=0, first_err_valid_o=0.
- Same config, modes 1, 2 and 3 back to back, each started the cycle done_o is seen -> each run passes with identical 34-cycle latency, and done_o drops for each new run.
- RAM_MARCH_ERR_INJ_EN defined, INJ_ADDR=5, mode 2 -> done_o at T+34, pass_o=0, err_cnt_o=1, first_err_valid_o=1, first_err_addr_o=5.
- Force the RAM read data bit via the bench for addresses 2..15 with ERR_CNT_W=3 -> err_cnt_o saturates at 7, first_err_addr_o=2, pass_o=0.
- Assert rst_i for 1 cycle during READ at addr 7 -> next cycle busy_o=0, done_o=0, err_cnt_o=0. A new start completes with pass_o=1 in 34 cycles.
- Pulse start_i repeatedly while busy_o=1 -> no restart; done_o timing is still T+34 from the first accepted start.
